// File: rtl/bridge_pkg.sv
// Shared types for the AHB-Lite to APB bridge: FSM states, HTRANS encodings and HRESP values.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_slave_decoder.sv
// Decodes the slave-index field of an AHB address into a one-hot APB select
// and flags indices that do not map to an existing slave.
module apb_slave_decoder
  import bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int NO_OF_SLAVES  = 8,
  parameter int SEL_LSB       = 16
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic [NO_OF_SLAVES-1:0]  sel,
  output logic                     valid
);

  localparam int IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

  logic [IDX_W-1:0] idx_s;
  logic             unused_addr;

  assign idx_s       = addr[SEL_LSB +: IDX_W];
  assign unused_addr = ^addr;

  // Index to one-hot; a single slave has a zero-width field and always matches.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    if (NO_OF_SLAVES == 1) begin
      sel[0] = 1'b1;
      valid  = 1'b1;
    end else begin
      for (int i = 0; i < NO_OF_SLAVES; i++) begin
        if (idx_s == i[IDX_W-1:0]) begin
          sel[i] = 1'b1;
          valid  = 1'b1;
        end else begin
          sel[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/modport_bridge.sv
// AHB-Lite slave to APB master bridge: one AHB transfer at a time, converted to an APB setup/access pair.
// Optional byte strobes on a PSTRB output when APB_PSTRB_EN is defined.
module modport_bridge
  import bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NO_OF_SLAVES  = 8,
  parameter int SEL_LSB       = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     HSEL,
  input  logic [ADDRESS_WIDTH-1:0] HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic [ADDRESS_WIDTH-1:0] PADDR,
  output logic                     PWRITE,
  output logic [DATA_WIDTH-1:0]    PWDATA,
  output logic [NO_OF_SLAVES-1:0]  PSELx,
  output logic                     PENABLE,
`ifdef APB_PSTRB_EN
  output logic [DATA_WIDTH/8-1:0]  PSTRB,
`endif
  input  logic [NO_OF_SLAVES-1:0]  PREADY,
  input  logic [NO_OF_SLAVES-1:0]  PSLVERR,
  input  logic [DATA_WIDTH-1:0]    PRDATA [NO_OF_SLAVES]
);

  bridge_state_t state_r;
  bridge_state_t next_state_s;

  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic                     write_r;
  logic [NO_OF_SLAVES-1:0]  sel_r;
  logic [2:0]               size_r;

  logic                     active_s;
  logic                     accept_s;
  logic [NO_OF_SLAVES-1:0]  dec_sel_s;
  logic                     dec_valid_s;
  logic                     pready_sel_s;
  logic                     pslverr_sel_s;
  logic [DATA_WIDTH-1:0]    prdata_sel_s;

  apb_slave_decoder #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NO_OF_SLAVES  (NO_OF_SLAVES),
    .SEL_LSB       (SEL_LSB)
  ) u_decoder (
    .addr  (HADDR),
    .sel   (dec_sel_s),
    .valid (dec_valid_s)
  );

  // Only NONSEQ/SEQ carry a transfer; IDLE and BUSY get a zero-wait OKAY.
  always_comb begin
    active_s = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: active_s = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active_s = 1'b0;
      default:                   active_s = 1'b0;
    endcase
  end

  assign accept_s = HSEL && HREADY && active_s &&
                    ((state_r == ST_IDLE) || (state_r == ST_ERR2));

  // PSELx stays one-hot on the addressed slave for the whole transfer, so it doubles as the return mux select.
  assign pready_sel_s  = |(PREADY & PSELx);
  assign pslverr_sel_s = |(PSLVERR & PSELx);

  // Read-data return mux.
  always_comb begin
    prdata_sel_s = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (PSELx[i]) begin
        prdata_sel_s = prdata_sel_s | PRDATA[i];
      end else begin
        prdata_sel_s = prdata_sel_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          next_state_s = dec_valid_s ? ST_LATCH : ST_ERR1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LATCH: next_state_s = ST_SETUP;
      ST_SETUP: next_state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_sel_s) begin
          next_state_s = pslverr_sel_s ? ST_ERR1 : ST_IDLE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_ERR1: next_state_s = ST_ERR2;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Address-phase capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r  <= '0;
      write_r <= 1'b0;
      sel_r   <= '0;
      size_r  <= 3'd0;
    end else if (accept_s) begin
      addr_r  <= HADDR;
      write_r <= HWRITE;
      sel_r   <= dec_sel_s;
      size_r  <= HSIZE;
    end
  end

`ifdef APB_PSTRB_EN
  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [LW-1:0] off);
    logic [NB-1:0] one_lane;
    logic [NB-1:0] two_lanes;
    logic [LW-1:0] half_off;
    one_lane  = {{(NB-1){1'b0}}, 1'b1};
    two_lanes = {{(NB-2){1'b0}}, 2'b11};
    half_off  = {off[LW-1:1], 1'b0};
    case (size)
      3'd0:    return one_lane << off;
      3'd1:    return two_lanes << half_off;
      default: return {NB{1'b1}};
    endcase
  endfunction

  // Strobes launch with PADDR; reads never assert a lane.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PSTRB <= '0;
    end else if (state_r == ST_LATCH) begin
      PSTRB <= write_r ? lane_mask(size_r, addr_r[LW-1:0]) : '0;
    end
  end
`else
  logic unused_size;
  assign unused_size = ^size_r;
`endif

  // APB request outputs; address and data launch on the LATCH->SETUP edge and hold through ACCESS.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSELx   <= '0;
      PENABLE <= 1'b0;
    end else begin
      if (state_r == ST_LATCH) begin
        PADDR  <= addr_r;
        PWRITE <= write_r;
        PWDATA <= HWDATA;
      end
      PSELx   <= ((next_state_s == ST_SETUP) || (next_state_s == ST_ACCESS)) ? sel_r : '0;
      PENABLE <= (next_state_s == ST_ACCESS);
    end
  end

  // AHB response outputs, registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
    end else begin
      HREADYOUT <= (next_state_s == ST_IDLE) || (next_state_s == ST_ERR2);
      HRESP     <= ((next_state_s == ST_ERR1) || (next_state_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      if ((state_r == ST_ACCESS) && pready_sel_s && !pslverr_sel_s && !PWRITE) begin
        HRDATA <= prdata_sel_s;
      end
    end
  end

endmodule

// File: tb/tb_modport_bridge.sv
// Self-checking bench for modport_bridge (six slaves so that indices 6 and 7 are decode errors).
module tb_modport_bridge;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          hsel = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic [1:0]    htrans = 2'b00;
  logic          hwrite = 1'b0;
  logic [2:0]    hsize = 3'd2;
  logic [DW-1:0] hwdata = '0;
  logic          hready = 1'b1;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [NS-1:0] pselx;
  logic          penable;
  logic [NS-1:0] pready = '0;
  logic [NS-1:0] pslverr = '0;
  logic [DW-1:0] prdata [NS];
`ifdef APB_PSTRB_EN
  logic [DW/8-1:0] pstrb;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] model_hrdata = 32'd0;

  modport_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .NO_OF_SLAVES  (NS),
    .SEL_LSB       (16)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .PADDR     (paddr),
    .PWRITE    (pwrite),
    .PWDATA    (pwdata),
    .PSELx     (pselx),
    .PENABLE   (penable),
`ifdef APB_PSTRB_EN
    .PSTRB     (pstrb),
`endif
    .PREADY    (pready),
    .PSLVERR   (pslverr),
    .PRDATA    (prdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Slave side: random noise on every slave, then the addressed one driven deliberately.
  task automatic drive_slaves(input int idx, input bit rdy, input bit err, input logic [31:0] rd);
    pready  = NS'($urandom);
    pslverr = NS'($urandom);
    for (int i = 0; i < NS; i++) prdata[i] = $urandom;
    if (idx >= 0 && idx < NS) begin
      pready[idx]  = rdy;
      pslverr[idx] = err;
      prdata[idx]  = rd;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pselx"}, 32'(pselx), 32'd0);
    chk({tag, "_penable"}, 32'(penable), 32'd0);
    chk({tag, "_paddr"}, paddr, 32'd0);
    chk({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    chk({tag, "_pwdata"}, pwdata, 32'd0);
    chk({tag, "_hrdata"}, hrdata, 32'd0);
    chk({tag, "_hresp"}, 32'(hresp), 32'd0);
    chk({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
  endtask

  // One AHB transfer, starting in a cycle where the bridge is ready and ending in the
  // final ready cycle of its data phase (so a follow-on transfer may start there).
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                      input int waits, input bit err, input logic [31:0] rd, input int reset_k);
    int idx;
    bit valid;
    logic [NS-1:0] exp_sel;
    idx = int'((addr >> 16) & 32'd7);
    valid = (idx < NS);
    exp_sel = valid ? (NS'(1) << idx) : '0;

    chk("c0_hreadyout", 32'(hreadyout), 32'd1);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = 3'd2; hready = 1'b1;
    drive_slaves(-1, 1'b0, 1'b0, 32'd0);
    step();

    hsel = 1'($urandom); htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom); hwdata = wdata;
    if (!valid) begin
      chk("derr1_hresp", 32'(hresp), 32'd1);
      chk("derr1_hreadyout", 32'(hreadyout), 32'd0);
      chk("derr1_pselx", 32'(pselx), 32'd0);
      step();
      chk("derr2_hresp", 32'(hresp), 32'd1);
      chk("derr2_hreadyout", 32'(hreadyout), 32'd1);
      chk("derr2_pselx", 32'(pselx), 32'd0);
      return;
    end
    chk("latch_hreadyout", 32'(hreadyout), 32'd0);
    chk("latch_hresp", 32'(hresp), 32'd0);
    chk("latch_pselx", 32'(pselx), 32'd0);
    step();

    hwdata = $urandom;
    chk("setup_pselx", 32'(pselx), 32'(exp_sel));
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", 32'(pwrite), 32'(wr));
    chk("setup_hreadyout", 32'(hreadyout), 32'd0);

    for (int k = 0; k <= waits; k++) begin
      step();
      chk("acc_penable", 32'(penable), 32'd1);
      chk("acc_pselx", 32'(pselx), 32'(exp_sel));
      chk("acc_paddr", paddr, addr);
      chk("acc_pwrite", 32'(pwrite), 32'(wr));
      chk("acc_hreadyout", 32'(hreadyout), 32'd0);
      if (wr) chk("acc_pwdata", pwdata, wdata);
      if (k == reset_k) begin
        reset_n = 1'b0;
        #1;
        model_hrdata = 32'd0;
        check_reset_outputs("rst_mid");
        step();
        reset_n = 1'b1;
        return;
      end
      drive_slaves(idx, k == waits, err && (k == waits), rd);
    end
    step();
    drive_slaves(-1, 1'b0, 1'b0, 32'd0);

    if (err) begin
      chk("serr1_hresp", 32'(hresp), 32'd1);
      chk("serr1_hreadyout", 32'(hreadyout), 32'd0);
      chk("serr1_pselx", 32'(pselx), 32'd0);
      chk("serr1_penable", 32'(penable), 32'd0);
      step();
      chk("serr2_hresp", 32'(hresp), 32'd1);
      chk("serr2_hreadyout", 32'(hreadyout), 32'd1);
      chk("serr2_hrdata", hrdata, model_hrdata);
    end else begin
      if (!wr) model_hrdata = rd;
      chk("done_hreadyout", 32'(hreadyout), 32'd1);
      chk("done_hresp", 32'(hresp), 32'd0);
      chk("done_pselx", 32'(pselx), 32'd0);
      chk("done_penable", 32'(penable), 32'd0);
      chk("done_hrdata", hrdata, model_hrdata);
    end
  endtask

  task automatic idle_check();
    hsel = 1'b0; htrans = 2'b00;
    step();
    chk("idle_hreadyout", 32'(hreadyout), 32'd1);
    chk("idle_hresp", 32'(hresp), 32'd0);
    chk("idle_pselx", 32'(pselx), 32'd0);
    chk("idle_penable", 32'(penable), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) prdata[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst_init");
    reset_n = 1'b1;
    idle_check();

    xfer(32'h0002_0004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'd0, -1);
    idle_check();
    xfer(32'h0005_0000, 1'b0, 32'd0, 3, 1'b0, 32'h1234_5678, -1);
    idle_check();
    xfer(32'h0001_0010, 1'b1, 32'hCAFE_F00D, 1, 1'b1, 32'd0, -1);
    idle_check();
    xfer(32'h0007_0000, 1'b1, 32'h0BAD_0BAD, 0, 1'b0, 32'd0, -1);
    idle_check();
    xfer(32'h0000_0100, 1'b0, 32'd0, 0, 1'b0, 32'hAAAA_5555, -1);
    xfer(32'h0003_0200, 1'b0, 32'd0, 0, 1'b0, 32'h5A5A_1234, -1);
    idle_check();
    xfer(32'h0004_0008, 1'b1, 32'h1111_2222, 3, 1'b0, 32'd0, 1);
    idle_check();

    // Transfers that must be ignored: BUSY, HSEL low, HREADY low.
    hsel = 1'b1; htrans = 2'b01; hready = 1'b1; haddr = 32'h0002_0000;
    step();
    chk("busy_hreadyout", 32'(hreadyout), 32'd1);
    hsel = 1'b0; htrans = 2'b10;
    step();
    chk("nosel_hreadyout", 32'(hreadyout), 32'd1);
    hsel = 1'b1; htrans = 2'b10; hready = 1'b0;
    step();
    chk("nordy_hreadyout", 32'(hreadyout), 32'd1);
    chk("nordy_pselx", 32'(pselx), 32'd0);
    hready = 1'b1;
    idle_check();

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFF8_FFFF) | ($urandom_range(0, 7) << 16);
      xfer(a, 1'($urandom), $urandom, int'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, $urandom, -1);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modport_bridge.md
Name: modport_bridge

Overview:
AHB-Lite slave to APB master bridge for the peripheral subsystem. Accepts one AHB transfer at a time and converts it into a two-phase APB transfer (setup, then access) to one of NO_OF_SLAVES APB slaves, which are selected one-hot through PSELx. The AHB data phase is stretched with HREADYOUT low until the APB slave completes. Per-slave PREADY, PSLVERR and PRDATA are multiplexed back to AHB.

Parameters:
ADDRESS_WIDTH, 32, HADDR/PADDR width
DATA_WIDTH, 32, HWDATA/HRDATA/PWDATA/PRDATA width
NO_OF_SLAVES, 8, number of APB slaves (1..16)
SEL_LSB, 16, LSB of the slave-index field in HADDR

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
HSEL  in  1  bridge selected
HADDR  in  ADDRESS_WIDTH  AHB address
HTRANS  in  2  AHB transfer type
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HWDATA  in  DATA_WIDTH  write data, valid in the data phase
HREADY  in  1  bus-level ready
HREADYOUT  out  1  bridge ready
HRESP  out  1  1 = ERROR
HRDATA  out  DATA_WIDTH  read data
PADDR  out  ADDRESS_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSELx  out  NO_OF_SLAVES  one-hot slave select
PENABLE  out  1  access phase
PREADY  in  NO_OF_SLAVES  per-slave ready
PSLVERR  in  NO_OF_SLAVES  per-slave error
PRDATA  in  NO_OF_SLAVES x DATA_WIDTH  per-slave read data (unpacked array)

Behaviour:
- Reset (asynchronous, immediate even mid-transfer):
  - state IDLE; PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, HRDATA=0, HRESP=0, HREADYOUT=1.
  - Any in-flight transfer is abandoned.
- Transfer accepted when HSEL & HTRANS[1] & HREADY, in state IDLE or ERR2. HTRANS IDLE/BUSY are ignored (OKAY, zero wait).
- Slave index = HADDR[SEL_LSB +: clog2(NO_OF_SLAVES)].
  - If index >= NO_OF_SLAVES: decode error, go directly to ERR1; no APB activity.
- On acceptance, register HADDR, HWRITE, index and HSIZE.
- States: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. Accept valid transfer -> LATCH (or ERR1 on decode error).
- LATCH: HREADYOUT=0. Capture HWDATA into PWDATA at the end of the cycle (reads too; value unused). -> SETUP.
- SETUP: PADDR = latched address, PWRITE = latched HWRITE, PSELx[index]=1, PENABLE=0. -> ACCESS.
- ACCESS: PENABLE=1; PSELx, PADDR, PWRITE, PWDATA held stable. Wait while PREADY[index]=0.
  - On PREADY[index]=1 and PSLVERR[index]=0: HRDATA <= PRDATA[index] (reads only), PSELx/PENABLE cleared -> IDLE.
  - On PREADY[index]=1 and PSLVERR[index]=1: -> ERR1.
- ERR1: HRESP=1, HREADYOUT=0, PSELx=0, PENABLE=0. -> ERR2.
- ERR2: HRESP=1, HREADYOUT=1. -> IDLE, or LATCH/ERR1 if a new transfer is accepted this cycle.
- Latency: address phase in cycle 0; zero-wait APB slave completes in cycle 3; AHB data phase ends in cycle 4 (HREADYOUT high). Each APB wait state adds one cycle.
- HRDATA holds its last value until the next successful read.
- PSLVERR and PREADY of non-selected slaves are ignored.

Optional Feature:
APB_PSTRB_EN:
- Defined: adds output PSTRB (DATA_WIDTH/8 bits), registered with PADDR in SETUP.
  - Writes: byte lanes from HSIZE and HADDR[1:0] (byte = 1 lane, halfword = 2, word = all).
  - Reads: 0.
  - Reset value: 0.
- Undefined: no PSTRB port; HSIZE is latched but unused.

Decomposition:
- Package bridge_pkg: state enum, HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HRESP OKAY/ERROR constants.
- One sub-module, apb_slave_decoder: address -> one-hot select plus decode-valid flag.

Test Plan:
- Reset asserted mid-ACCESS -> all APB outputs 0 and HREADYOUT=1 immediately, state IDLE.
- Write HADDR=0x0002_0004, HWDATA=0xDEADBEEF, slave 2 PREADY=1 -> PSELx=0x04, PADDR=0x0002_0004, PWDATA=0xDEADBEEF, PENABLE high in cycle 3, HREADYOUT high in cycle 4.
- Read HADDR=0x0005_0000, PRDATA[5]=0x1234_5678, PREADY[5] low for 3 cycles -> PENABLE held 4 cycles, HRDATA=0x1234_5678, HRESP=0.
- Write to slave 1 with PSLVERR[1]=1 at completion -> HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1, then IDLE.
- NO_OF_SLAVES=6, HADDR=0x0007_0000 -> no PSELx activity, two-cycle ERROR response.
- Back-to-back NONSEQ reads to slaves 0 and 3 -> second transfer accepted in the IDLE cycle that ends the first; PSELx 0x01 then 0x08.
